ripple_count_capture: RTL and testbench
=======================================

# ripple_count_capture

Clock-domain capture stage that sits directly downstream of the 4-bit asynchronous ripple counter. It samples the counter's glitch-prone, non-Gray output into the `clk` domain and accepts only settled values. It accumulates the modulo-2^IN_W deltas into a wide extended count and offers a valid/ready snapshot port to software-facing logic.

## Interface
- `IN_W`, default 4: width of the ripple count input.
- `EXT_W`, default 16: width of the extended accumulated count.
- `SYNC_STAGES`, default 2: synchronizer depth, minimum 2.
- `STALL_MAX`, default 8: number of consecutive unsettled cycles that flags an error.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high. It is shared with the ripple counter.
- `cnt_in` in IN_W: ripple counter value, asynchronous to `clk`.
- `clr` in 1: synchronous clear of the extended count and error flag.
- `snap_req` in 1: single-cycle snapshot request.
- `snap_ready` in 1: consumer accepts the snapshot.
- `snap_valid` out 1: snapshot held and valid.
- `snap_count` out EXT_W: snapshot value.
- `ext_count` out EXT_W: running extended count.
- `ext_wrap` out 1: single-cycle pulse when `ext_count` wraps past all-ones.
- `err` out 1: sticky flag for input unsettled too long.

## Operation
- Reset values: all synchronizer flops, `prev`, `last`, `ext_count`, `snap_count` = 0; `snap_valid`, `ext_wrap`, `err` = 0; snapshot FSM = IDLE.
- Every bit of `cnt_in` passes through a SYNC_STAGES flop chain. The chain output is `s`, and `prev` is `s` registered one more cycle.
- Settled: `s == prev`. Only settled cycles update the count, so ripple transients are never accumulated.
- On a settled cycle: `delta = (s - last) mod 2^IN_W`, zero-extended to EXT_W. Then `ext_count <= ext_count + delta` mod 2^EXT_W, and `last <= s`.
- `ext_wrap` pulses for one cycle when that addition carries out of EXT_W.
- Usage constraint: fewer than 2^IN_W ripple counts between settled samples. Exceeding it silently loses multiples of 2^IN_W; this is not detected.
- `clr`: `ext_count <= 0`, `last <= s`, `err <= 0`, FSM to IDLE, `snap_valid <= 0`. `clr` overrides a coincident settled update and a coincident snapshot request.
- Snapshot FSM:
  - IDLE: on `snap_req`, go to WAIT.
  - WAIT: on the next settled cycle, `snap_count <=` the post-update `ext_count` and go to HOLD.
  - HOLD: `snap_valid = 1` and `snap_count` is stable. On `snap_ready`, go to IDLE; `snap_valid` drops the next cycle.
- `snap_req` is ignored in WAIT and HOLD. `snap_ready` is ignored outside HOLD.
- `rst` mid-operation clears all state immediately; no partial snapshot survives.

## Timing
- `cnt_in` constant from before edge k makes `s` valid after edge k+SYNC_STAGES-1.
- The settled compare is true on the following cycle, so `ext_count` reflects the value no later than edge k+SYNC_STAGES+1 (4 cycles at default).
- `snap_valid` rises 1 cycle after the settled cycle that follows the request, with a minimum 1 cycle after `snap_req`.
- A back-to-back `snap_req` is accepted on the same cycle `snap_valid` falls.
- `ext_wrap` and `snap_valid` are registered outputs. There are no combinational paths from inputs to outputs.

## Configuration
- `RCC_STALL_DET_EN` defined: a saturating stall counter is compiled in.
  - It counts consecutive unsettled cycles and resets on a settled cycle.
  - When it reaches STALL_MAX, `err` is set and holds until `clr` or `rst`.
- `RCC_STALL_DET_EN` undefined: the counter is absent and `err` is tied to 0.

## Structure
- Package `rcc_pkg`: the snapshot state enum (IDLE, WAIT, HOLD) and default width constants for IN_W, EXT_W and SYNC_STAGES.
- Sub-module `sync_bus`: a parameterized width × depth flop synchronizer with asynchronous reset, instantiated once for `cnt_in`.
- The delta, accumulate, FSM and stall logic stay in the top module.

## Test plan
- Reset with `cnt_in` = 0, then advance the ripple counter by 5 slowly (≥8 clk per count) → `ext_count` = 5, `err` = 0, no `ext_wrap`.
- Ripple counter wraps 14 → 15 → 0 → 3 → `ext_count` advances by 5 total; the modulo delta is correct across the 4-bit wrap.
- Preload `ext_count` to 0xFFFE via counting, then add 3 → `ext_count` = 0x0001 with one `ext_wrap` pulse.
- `snap_req` with `snap_ready` held low for 10 cycles while counting continues → `snap_count` frozen, `snap_valid` = 1 throughout. Raise `snap_ready` → `snap_valid` = 0 on the next cycle.
- `cnt_in` driven with a toggling glitch pattern every cycle for 8 cycles, macro defined → `err` = 1 and `ext_count` unchanged. Then `clr` → `err` = 0 and `ext_count` = 0.
- `clr` asserted on the same cycle as a settled update and a `snap_req` → `ext_count` = 0, FSM IDLE, no `snap_valid`. Later counts accumulate from the new `last`.

Source files
------------

// File: rtl/rcc_pkg.sv
// Shared types and default widths for the ripple-count capture stage.
package rcc_pkg;

  // Snapshot handshake states.
  typedef enum logic [1:0] {
    SNAP_IDLE = 2'd0,
    SNAP_WAIT = 2'd1,
    SNAP_HOLD = 2'd2
  } snap_state_e;

  localparam int RCC_IN_W        = 4;
  localparam int RCC_EXT_W       = 16;
  localparam int RCC_SYNC_STAGES = 2;
  localparam int RCC_STALL_MAX   = 8;

endpackage

// File: rtl/sync_bus.sv
// Width x depth flop synchronizer with asynchronous active-high reset.
// Bits are synchronized independently; the consumer must tolerate
// incoherent multi-bit samples (the capture stage filters them by
// requiring two identical consecutive samples).
module sync_bus #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] chain_q [DEPTH];

  // Shift the asynchronous input through DEPTH flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q_o = chain_q[DEPTH-1];

endmodule

// File: rtl/ripple_count_capture.sv
// Capture stage downstream of an asynchronous ripple counter.
// Synchronizes the glitch-prone count, accepts only settled samples
// (two identical consecutive synchronized values), accumulates the
// modulo-2^IN_W deltas into an EXT_W extended count and offers a
// valid/ready snapshot port.
// Optional feature macro: RCC_STALL_DET_EN enables the stall detector
// driving err; when undefined err is tied low.
// SYNC_STAGES must be at least 2.
module ripple_count_capture
  import rcc_pkg::*;
#(
  parameter int IN_W        = RCC_IN_W,
  parameter int EXT_W       = RCC_EXT_W,
  parameter int SYNC_STAGES = RCC_SYNC_STAGES,
  parameter int STALL_MAX   = RCC_STALL_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  cnt_in,
  input  logic             clr,
  input  logic             snap_req,
  input  logic             snap_ready,
  output logic             snap_valid,
  output logic [EXT_W-1:0] snap_count,
  output logic [EXT_W-1:0] ext_count,
  output logic             ext_wrap,
  output logic             err
);

  logic [IN_W-1:0]  s;
  logic [IN_W-1:0]  prev_q;
  logic [IN_W-1:0]  last_q;
  logic [EXT_W-1:0] ext_q;
  logic [EXT_W-1:0] ext_d;
  logic [EXT_W-1:0] snap_q;
  logic             wrap_q;
  logic             valid_q;
  snap_state_e      state_q;

  logic             settled;
  logic [IN_W-1:0]  delta;
  logic [EXT_W:0]   sum;

  sync_bus #(
    .W     (IN_W),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (cnt_in),
    .q_o (s)
  );

  // A sample is trusted only when it matches the previous one, so a
  // ripple transient caught mid-flight never reaches the accumulator.
  assign settled = (s == prev_q);
  assign delta   = s - last_q;
  assign sum     = {1'b0, ext_q} + {{(EXT_W + 1 - IN_W){1'b0}}, delta};
  assign ext_d   = sum[EXT_W-1:0];

  // Delay the synchronized value one cycle for the settled compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= s;
  end

  // Accumulate settled deltas; clr restarts counting from the current sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q  <= '0;
      last_q <= '0;
      wrap_q <= 1'b0;
    end else if (clr) begin
      ext_q  <= '0;
      last_q <= s;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= settled & sum[EXT_W];
      if (settled) begin
        ext_q  <= ext_d;
        last_q <= s;
      end
    end
  end

  // Snapshot FSM: capture the post-update count on the first settled
  // cycle after a request and hold it until the consumer accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SNAP_IDLE;
      valid_q <= 1'b0;
      snap_q  <= '0;
    end else if (clr) begin
      state_q <= SNAP_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        SNAP_IDLE: begin
          if (snap_req) state_q <= SNAP_WAIT;
        end
        SNAP_WAIT: begin
          if (settled) begin
            snap_q  <= ext_d;
            valid_q <= 1'b1;
            state_q <= SNAP_HOLD;
          end
        end
        SNAP_HOLD: begin
          if (snap_ready) begin
            valid_q <= 1'b0;
            state_q <= SNAP_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= SNAP_IDLE;
        end
      endcase
    end
  end

`ifdef RCC_STALL_DET_EN
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  logic [STALL_W-1:0] stall_q;
  logic [STALL_W-1:0] stall_d;
  logic               err_q;

  // Saturating count of consecutive unsettled cycles.
  always_comb begin
    stall_d = stall_q;
    if (settled)
      stall_d = '0;
    else if (stall_q != STALL_W'(STALL_MAX))
      stall_d = stall_q + 1'b1;
  end

  // Sticky error once the input has been unsettled for STALL_MAX cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else if (clr) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      if (stall_d == STALL_W'(STALL_MAX)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_stall_max;
  assign unused_stall_max = (STALL_MAX > 0);
  assign err = 1'b0;
`endif

  assign ext_count  = ext_q;
  assign ext_wrap   = wrap_q;
  assign snap_valid = valid_q;
  assign snap_count = snap_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Self-checking bench for ripple_count_capture at default parameters.
module tb_ripple_count_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cnt_in;
  logic        clr;
  logic        snap_req;
  logic        snap_ready;
  logic        snap_valid;
  logic [15:0] snap_count;
  logic [15:0] ext_count;
  logic        ext_wrap;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wrap_seen = 0;

  // Reference model: the true ripple count and the expected extended count.
  logic [3:0]  cnt;
  logic [15:0] exp_ext;

`ifdef RCC_STALL_DET_EN
  localparam logic EXP_ERR_STALL = 1'b1;
`else
  localparam logic EXP_ERR_STALL = 1'b0;
`endif

  ripple_count_capture dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .clr        (clr),
    .snap_req   (snap_req),
    .snap_ready (snap_ready),
    .snap_valid (snap_valid),
    .snap_count (snap_count),
    .ext_count  (ext_count),
    .ext_wrap   (ext_wrap),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ext_wrap === 1'b1) wrap_seen++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input int inc, input int hold);
    cnt     = cnt + 4'(inc);
    cnt_in  = cnt;
    exp_ext = exp_ext + 16'(inc);
    tick(hold);
  endtask

  task automatic do_reset();
    rst = 1'b1; cnt = 4'd0; cnt_in = 4'd0; clr = 1'b0;
    snap_req = 1'b0; snap_ready = 1'b0; exp_ext = 16'd0;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; cnt = 4'd0; cnt_in = 4'd0; clr = 1'b0;
    snap_req = 1'b0; snap_ready = 1'b0; exp_ext = 16'd0;
    #1;
    n_checks++;
    if ({ext_count, snap_count, snap_valid, ext_wrap, err} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ext=%h snap=%h v=%b w=%b e=%b, want all 0",
               ext_count, snap_count, snap_valid, ext_wrap, err);
    end
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_slow_count();
    int base;
    base = wrap_seen;
    for (int i = 0; i < 5; i++) step(1, 8);
    n_checks++;
    if (ext_count !== 16'd5) begin
      n_fail++; $display("FAIL slow_count: ext_count=%0d want 5", ext_count);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL slow_err: err=%b want 0", err);
    end
    n_checks++;
    if (wrap_seen != base) begin
      n_fail++; $display("FAIL slow_wrap: pulses=%0d want 0", wrap_seen - base);
    end
  endtask

  task automatic test_nibble_wrap();
    logic [15:0] start;
    step(int'(4'd14 - cnt), 8);
    start = exp_ext;
    step(1, 8);
    step(1, 8);
    step(3, 8);
    n_checks++;
    if (ext_count !== start + 16'd5) begin
      n_fail++; $display("FAIL nibble_wrap: ext_count=%h want %h", ext_count, start + 16'd5);
    end
  endtask

  task automatic test_random_count();
    for (int i = 0; i < 25; i++) begin
      step(int'($urandom_range(15, 1)), int'($urandom_range(10, 4)));
      n_checks++;
      if (ext_count !== exp_ext) begin
        n_fail++; $display("FAIL random_count[%0d]: ext_count=%h want %h", i, ext_count, exp_ext);
      end
    end
  endtask

  task automatic test_ext_wrap();
    int base;
    int total;
    do_reset();
    base  = wrap_seen;
    total = 0;
    while (total < 65534) begin
      int inc;
      inc = (65534 - total > 15) ? 15 : 65534 - total;
      step(inc, 4);
      total += inc;
    end
    tick(4);
    n_checks++;
    if (ext_count !== 16'hFFFE) begin
      n_fail++; $display("FAIL preload: ext_count=%h want fffe", ext_count);
    end
    n_checks++;
    if (wrap_seen != base) begin
      n_fail++; $display("FAIL preload_wrap: pulses=%0d want 0", wrap_seen - base);
    end
    step(3, 8);
    n_checks++;
    if (ext_count !== 16'h0001) begin
      n_fail++; $display("FAIL ext_wrap_value: ext_count=%h want 0001", ext_count);
    end
    n_checks++;
    if (wrap_seen != base + 1) begin
      n_fail++; $display("FAIL ext_wrap_pulse: pulses=%0d want 1", wrap_seen - base);
    end
  endtask

  task automatic test_snapshot_hold();
    logic [15:0] frozen;
    bit          seen;
    tick(4);
    snap_req = 1'b1;
    tick(1);
    snap_req = 1'b0;
    n_checks++;
    if (snap_valid !== 1'b0) begin
      n_fail++; $display("FAIL snap_early: snap_valid=%b want 0", snap_valid);
    end
    tick(1);
    n_checks++;
    if (snap_valid !== 1'b1 || snap_count !== exp_ext) begin
      n_fail++; $display("FAIL snap_capture: v=%b count=%h want 1 %h", snap_valid, snap_count, exp_ext);
    end
    frozen = exp_ext;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step(1, 1); else tick(1);
      n_checks++;
      if (snap_valid !== 1'b1 || snap_count !== frozen) begin
        n_fail++; $display("FAIL snap_frozen[%0d]: v=%b count=%h want 1 %h", i, snap_valid, snap_count, frozen);
      end
    end
    tick(4);
    n_checks++;
    if (ext_count !== exp_ext) begin
      n_fail++; $display("FAIL snap_running: ext_count=%h want %h", ext_count, exp_ext);
    end
    snap_ready = 1'b1;
    tick(1);
    snap_ready = 1'b0;
    n_checks++;
    if (snap_valid !== 1'b0) begin
      n_fail++; $display("FAIL snap_release: snap_valid=%b want 0", snap_valid);
    end
    // Back-to-back request in the cycle the previous snapshot dropped.
    snap_req = 1'b1;
    tick(1);
    snap_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      if (snap_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || snap_count !== exp_ext) begin
      n_fail++; $display("FAIL back_to_back: seen=%b count=%h want 1 %h", seen, snap_count, exp_ext);
    end
    snap_ready = 1'b1;
    tick(1);
    snap_ready = 1'b0;
    tick(1);
  endtask

  task automatic test_glitch_stall();
    logic [3:0] c;
    c = cnt;
    for (int i = 0; i < 12; i++) begin
      cnt_in = (i % 2 == 0) ? (c ^ 4'hA) : c;
      tick(1);
    end
    n_checks++;
    if (ext_count !== exp_ext) begin
      n_fail++; $display("FAIL glitch_hold: ext_count=%h want %h", ext_count, exp_ext);
    end
    cnt_in = c;
    tick(6);
    n_checks++;
    if (ext_count !== exp_ext) begin
      n_fail++; $display("FAIL glitch_after: ext_count=%h want %h", ext_count, exp_ext);
    end
    n_checks++;
    if (err !== EXP_ERR_STALL) begin
      n_fail++; $display("FAIL stall_err: err=%b want %b", err, EXP_ERR_STALL);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_ext = 16'd0;
    n_checks++;
    if (err !== 1'b0 || ext_count !== 16'd0) begin
      n_fail++; $display("FAIL clr_err: err=%b ext=%h want 0 0000", err, ext_count);
    end
    step(3, 6);
    n_checks++;
    if (ext_count !== exp_ext) begin
      n_fail++; $display("FAIL clr_recount: ext_count=%h want %h", ext_count, exp_ext);
    end
  endtask

  task automatic test_clr_coincident();
    step(2, 3);
    clr = 1'b1;
    snap_req = 1'b1;
    tick(1);
    clr = 1'b0;
    snap_req = 1'b0;
    exp_ext = 16'd0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ext_count !== 16'd0 || snap_valid !== 1'b0) begin
        n_fail++; $display("FAIL clr_coincident[%0d]: ext=%h v=%b want 0000 0", i, ext_count, snap_valid);
      end
      tick(1);
    end
    step(4, 8);
    n_checks++;
    if (ext_count !== 16'd4) begin
      n_fail++; $display("FAIL clr_new_last: ext_count=%h want 0004", ext_count);
    end
  endtask

  task automatic test_reset_mid();
    snap_req = 1'b1;
    tick(1);
    snap_req = 1'b0;
    tick(2);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (snap_valid !== 1'b0 || ext_count !== 16'd0 || snap_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid: v=%b ext=%h snap=%h want 0", snap_valid, ext_count, snap_count);
    end
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_slow_count();
    test_nibble_wrap();
    test_random_count();
    test_snapshot_hold();
    test_glitch_stall();
    test_clr_coincident();
    test_ext_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
